// File: rtl/alu_arbiter_if.sv
// Bundle of requester handshakes and the ALU-facing bus for alu_arbiter.
// The slave modport is the arbiter's view; the master modport is the
// requester/ALU environment's view.
interface alu_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int WORD_SIZE   = 16,
  parameter int OPCODE_SIZE = 4
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*OPCODE_SIZE-1:0] req_opcode;
  logic [NUM_REQ*WORD_SIZE-1:0]   req_input1;
  logic [NUM_REQ*WORD_SIZE-1:0]   req_input2;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [NUM_REQ-1:0]             resp_ready;
  logic [WORD_SIZE-1:0]           resp_data;
  logic [OPCODE_SIZE-1:0]         alu_opcode;
  logic [WORD_SIZE-1:0]           alu_input1;
  logic [WORD_SIZE-1:0]           alu_input2;
  logic                           alu_enable;
  logic [WORD_SIZE-1:0]           alu_out;

  modport slave (
    input  req_valid, req_opcode, req_input1, req_input2, resp_ready, alu_out,
    output req_ready, resp_valid, resp_data,
    output alu_opcode, alu_input1, alu_input2, alu_enable
  );

  modport master (
    output req_valid, req_opcode, req_input1, req_input2, resp_ready, alu_out,
    input  req_ready, resp_valid, resp_data,
    input  alu_opcode, alu_input1, alu_input2, alu_enable
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between NUM_REQ requesters.
// One operation is in flight at a time: IDLE -> ISSUE -> CAPTURE -> RESP.
module alu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WORD_SIZE   = 16,
  parameter int OPCODE_SIZE = 4
) (
  input  logic          clock,
  input  logic          reset,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so last_grant + k can exceed NUM_REQ before wrapping.
  localparam int CW    = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       owner_reg;
  logic [IDX_W-1:0]       last_grant_reg;
  logic [OPCODE_SIZE-1:0] opcode_reg;
  logic [WORD_SIZE-1:0]   input1_reg;
  logic [WORD_SIZE-1:0]   input2_reg;
  logic [WORD_SIZE-1:0]   resp_data_reg;

  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_found;
  logic [CW-1:0]          cand;
  logic [NUM_REQ-1:0]     ready_vec;

  logic [OPCODE_SIZE-1:0] opcode_arr [NUM_REQ];
  logic [WORD_SIZE-1:0]   input1_arr [NUM_REQ];
  logic [WORD_SIZE-1:0]   input2_arr [NUM_REQ];

  // Unpack the flattened request payloads and drive the one-hot response valid.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);
      assign opcode_arr[gi]     = bus.req_opcode[gi*OPCODE_SIZE +: OPCODE_SIZE];
      assign input1_arr[gi]     = bus.req_input1[gi*WORD_SIZE +: WORD_SIZE];
      assign input2_arr[gi]     = bus.req_input2[gi*WORD_SIZE +: WORD_SIZE];
      assign bus.resp_valid[gi] = (state_reg == RESP) && (owner_reg == GI_IDX);
    end
  endgenerate

  // Round-robin pick: first valid requester after last_grant, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_reg} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!grant_found && bus.req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state logic and the accept strobe; a grant happens only in IDLE.
  always_comb begin
    state_next = state_reg;
    ready_vec  = '0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          ready_vec[grant_idx] = 1'b1;
          state_next           = ISSUE;
        end
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP: begin
        if (bus.resp_ready[owner_reg]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latch the winner's payload on accept and the ALU result in CAPTURE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_reg      <= '0;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      opcode_reg     <= '0;
      input1_reg     <= '0;
      input2_reg     <= '0;
      resp_data_reg  <= '0;
    end else begin
      if (state_reg == IDLE && grant_found) begin
        owner_reg      <= grant_idx;
        last_grant_reg <= grant_idx;
        opcode_reg     <= opcode_arr[grant_idx];
        input1_reg     <= input1_arr[grant_idx];
        input2_reg     <= input2_arr[grant_idx];
      end
      if (state_reg == CAPTURE) begin
        resp_data_reg <= bus.alu_out;
      end
    end
  end

  // Accept strobe is held low while reset is asserted so every output reads 0.
  assign bus.req_ready  = reset ? '0 : ready_vec;
  assign bus.resp_data  = resp_data_reg;
  // ALU inputs come straight from registers so they never glitch.
  assign bus.alu_opcode = opcode_reg;
  assign bus.alu_input1 = input1_reg;
  assign bus.alu_input2 = input2_reg;
  assign bus.alu_enable = (state_reg == ISSUE);
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural one-cycle registered ALU.
module tb_alu_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int O = 4;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLI = 4'h6;
  localparam logic [3:0] OP_BAD = 4'hF;

  logic clock = 1'b0;
  logic reset;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cycle_cnt = 0;
  int   c0;

  alu_arbiter_if #(.NUM_REQ(N), .WORD_SIZE(W), .OPCODE_SIZE(O)) bus ();

  alu_arbiter #(.NUM_REQ(N), .WORD_SIZE(W), .OPCODE_SIZE(O)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  // Registered ALU: undecoded opcodes leave alu_out unchanged.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.alu_out <= '0;
    end else if (bus.alu_enable) begin
      case (bus.alu_opcode)
        OP_ADD:  bus.alu_out <= bus.alu_input1 + bus.alu_input2;
        OP_SUB:  bus.alu_out <= bus.alu_input1 - bus.alu_input2;
        OP_XOR:  bus.alu_out <= bus.alu_input1 ^ bus.alu_input2;
        OP_SLI:  bus.alu_out <= bus.alu_input1 << bus.alu_input2;
        default: bus.alu_out <= bus.alu_out;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    bus.req_opcode[i*O +: O] = op;
    bus.req_input1[i*W +: W] = a;
    bus.req_input2[i*W +: W] = b;
  endtask

  // Entered 1 time unit after the edge that starts an IDLE cycle with req_valid
  // already driven; returns 1 time unit after the edge that ends the operation.
  task automatic run_op(input int who, input logic [15:0] exp, input bit drop,
                        input int hold, input logic [3:0] raise);
    logic [3:0] oh;
    oh = 4'b0001 << who;
    #1;
    check("grant", bus.req_ready, oh);
    check("idle_busy", busy, 1'b0);
    next_cycle();
    if (drop) bus.req_valid[who] = 1'b0;
    #1;
    check("issue_enable", bus.alu_enable, 1'b1);
    check("issue_busy", busy, 1'b1);
    check("issue_no_ready", bus.req_ready, 4'b0000);
    next_cycle();
    #1;
    check("capture_enable", bus.alu_enable, 1'b0);
    check("capture_no_resp", bus.resp_valid, 4'b0000);
    next_cycle();
    bus.req_valid = bus.req_valid | raise;
    #1;
    check("resp_valid", bus.resp_valid, oh);
    check("resp_data", bus.resp_data, exp);
    for (int h = 0; h < hold; h++) begin
      bus.resp_ready = ~oh;
      next_cycle();
      #1;
      check("hold_valid", bus.resp_valid, oh);
      check("hold_data", bus.resp_data, exp);
      check("hold_no_ready", bus.req_ready, 4'b0000);
    end
    bus.resp_ready = oh;
    #1;
    check("accept_no_ready", bus.req_ready, 4'b0000);
    next_cycle();
    bus.resp_ready = '0;
    $display("txn: requester %0d result 0x%04h cycle %0d", who, exp, cycle_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.req_valid  = '1;
    bus.req_opcode = '0;
    bus.req_input1 = '0;
    bus.req_input2 = '0;
    bus.resp_ready = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", bus.req_ready, 4'b0000);
    check("rst_resp_valid", bus.resp_valid, 4'b0000);
    check("rst_alu_enable", bus.alu_enable, 1'b0);
    check("rst_resp_data", bus.resp_data, 16'h0000);
    check("rst_alu_opcode", bus.alu_opcode, 4'h0);
    bus.req_valid = '0;
    reset = 1'b0;
    next_cycle();

    // Single ADD from requester 0.
    set_req(0, OP_ADD, 16'h0005, 16'h0003);
    bus.req_valid = 4'b0001;
    run_op(0, 16'h0008, 1'b1, 0, 4'b0000);

    // All requesters valid from a fresh pointer: order 0,1,2,3,0.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, OP_ADD, 16'(i + 1), 16'h0010);
    bus.req_valid = 4'b1111;
    c0 = cycle_cnt;
    for (int k = 0; k < 5; k++) run_op(k % N, 16'(17 + (k % N)), 1'b0, 0, 4'b0000);
    bus.req_valid = '0;
    check("rr_period", cycle_cnt - c0, 20);

    // Backpressure on requester 2; requester 3 waits and is granted next.
    set_req(2, OP_SUB, 16'h0001, 16'h0002);
    set_req(3, OP_XOR, 16'h00F0, 16'h000F);
    bus.req_valid = 4'b1100;
    run_op(2, 16'hFFFF, 1'b1, 5, 4'b0000);
    run_op(3, 16'h00FF, 1'b1, 0, 4'b0000);

    // Requests raised during requester 1's response: 3 then 0.
    set_req(1, OP_ADD, 16'h1234, 16'h0001);
    set_req(0, OP_ADD, 16'h0100, 16'h0200);
    set_req(3, OP_XOR, 16'hFFFF, 16'h00FF);
    bus.req_valid = 4'b0010;
    run_op(1, 16'h1235, 1'b1, 0, 4'b1001);
    run_op(3, 16'hFF00, 1'b1, 0, 4'b0000);
    run_op(0, 16'h0300, 1'b1, 0, 4'b0000);

    // Reset during CAPTURE discards the operation.
    set_req(0, OP_XOR, 16'hFFFF, 16'h00FF);
    bus.req_valid = 4'b0001;
    #1;
    check("mid_grant", bus.req_ready, 4'b0001);
    next_cycle();
    bus.req_valid = '0;
    next_cycle();
    #1;
    check("mid_busy", busy, 1'b1);
    check("mid_old_data", bus.resp_data, 16'h0300);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_resp_valid", bus.resp_valid, 4'b0000);
    check("mid_rst_enable", bus.alu_enable, 1'b0);
    check("mid_rst_data", bus.resp_data, 16'h0000);
    check("mid_rst_input1", bus.alu_input1, 16'h0000);
    next_cycle();
    check("mid_rst_no_resp", bus.resp_valid, 4'b0000);
    reset = 1'b0;

    // After reset requester 0 wins; then SLI and an undecoded opcode.
    set_req(3, OP_SLI, 16'h0001, 16'h0004);
    bus.req_valid = 4'b1001;
    run_op(0, 16'hFF00, 1'b1, 0, 4'b0000);
    run_op(3, 16'h0010, 1'b1, 0, 4'b0000);
    set_req(0, OP_BAD, 16'h1234, 16'h5678);
    bus.req_valid = 4'b0001;
    run_op(0, 16'h0010, 1'b1, 0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered ALU (one-cycle `alu_out` latency) between NUM_REQ independent requesters, e.g. the fetch/decode engine and the address-generation unit.
- Each requester issues opcode + two operands over a valid/ready handshake and receives its result on a one-hot response handshake.
- Grants are round-robin; one operation is in flight at a time.
- Sits between requesters and the alu instance; drives its `opcode`, `input1`, `input2` and `alu_enable`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WORD_SIZE, 16, operand/result width; must match the ALU.
- OPCODE_SIZE, 4, opcode width; must match the ALU.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept strobe; at most one bit high.
- req_opcode  in  NUM_REQ*OPCODE_SIZE  flattened opcodes, requester i at [i*OPCODE_SIZE +: OPCODE_SIZE].
- req_input1  in  NUM_REQ*WORD_SIZE  flattened first operands.
- req_input2  in  NUM_REQ*WORD_SIZE  flattened second operands.
- resp_valid  out  NUM_REQ  one-hot result valid to the owning requester.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_data  out  WORD_SIZE  result, shared by all requesters.
- alu_opcode  out  OPCODE_SIZE  to ALU opcode.
- alu_input1  out  WORD_SIZE  to ALU input1.
- alu_input2  out  WORD_SIZE  to ALU input2.
- alu_enable  out  1  to ALU alu_enable.
- alu_out  in  WORD_SIZE  from ALU alu_out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - Owner, latched opcode/operands, resp_data and all outputs are 0.
  - Priority pointer last_grant = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, CAPTURE, RESP (2-bit encoding).
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning last_grant+1, last_grant+2, … modulo NUM_REQ (wrap-around).
  - req_ready[winner] = 1 combinationally, in this cycle only.
  - At the clock edge: latch opcode/operands of the winner, owner <= winner, last_grant <= winner, go to ISSUE.
  - If no req_valid is set, stay in IDLE; req_ready = 0.
- ISSUE:
  - alu_enable = 1 for exactly this cycle.
  - alu_opcode/input1/input2 are driven from the latched registers.
  - Next state is CAPTURE.
- CAPTURE:
  - alu_out is valid this cycle.
  - resp_data <= alu_out at the edge; next state is RESP.
- RESP:
  - resp_valid[owner] = 1 and resp_data is held.
  - When resp_ready[owner] = 1, go to IDLE at the edge.
  - resp_ready on other bits is ignored.
  - resp_valid stays high indefinitely until accepted (backpressure).
- Outside ISSUE, alu_enable = 0. alu_opcode/alu_input1/alu_input2 always reflect the latched registers (stable, no glitching to the ALU).
- Latency: request accepted at edge T, alu_enable in cycle T+1, resp_valid asserted from cycle T+3. Minimum 4 cycles per operation (IDLE→ISSUE→CAPTURE→RESP→IDLE).
- Requests are never accepted outside IDLE. req_valid held by other requesters during an operation is queued implicitly and arbitrated on return to IDLE.
- Requester protocol: req_valid and its payload stay stable until req_ready. The arbiter samples the payload only in the accept cycle.
- Opcodes are passed through unchecked. For opcodes the ALU does not decode, alu_out retains its previous value and that value is returned. This is defined behaviour and is not flagged.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. The in-flight result is discarded and no resp_valid is issued.
- No combinational path from resp_ready to req_ready in the same cycle. A new grant occurs no earlier than the cycle after response acceptance.

Test Plan:
- Reset, then req_valid=0001 with `ADD`, 16'h0005, 16'h0003 → req_ready=0001 in cycle 0; alu_enable high in cycle 1 only; resp_valid=0001 with resp_data=16'h0008 from cycle 3; busy high cycles 1–3.
- req_valid=1111 held continuously, resp_ready=1111 → grant order 0,1,2,3,0 (pointer wraps); one response per 4 cycles; never two req_ready bits high.
- Requester 2 `SUB` 16'h0001, 16'h0002 with resp_ready[2] held 0 for 5 cycles → resp_valid=0100 and resp_data=16'hFFFF held stable all 5 cycles; no new grant until one cycle after resp_ready[2]=1.
- While requester 1 is in RESP, raise req_valid[0] and req_valid[3] → after acceptance, requester 3 is granted next (pointer at 1), then requester 0.
- Assert reset during CAPTURE of `XOR` 16'hFFFF, 16'h00FF → busy, resp_valid, alu_enable and resp_data go 0 asynchronously; after release, requester 0 is granted first.
- `SLI` 16'h0001 by 16'h0004, then an undefined opcode from another requester → first result 16'h0010; second result also 16'h0010 (ALU output retained).
